// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: dispatch FSM states,
// default register addresses and vector layout, and the vector helper.
package irq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQUEST  = 2'd1,
        ST_DISPATCH = 2'd2
    } irq_state_e;

    localparam int          IRQ_MAX_CH     = 8;
    localparam int          IRQ_ID_W       = 3;
    localparam logic [15:0] IRQ_IF_ADDR    = 16'hFF0F;
    localparam logic [15:0] IRQ_IE_ADDR    = 16'hFFFF;
    localparam logic [15:0] IRQ_VEC_BASE   = 16'h0040;
    localparam int          IRQ_VEC_STRIDE = 8;

    function automatic logic [15:0] irq_vector(
        input logic [15:0]         base,
        input int                  stride,
        input logic [IRQ_ID_W-1:0] id
    );
        return base + 16'(stride) * {13'd0, id};
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: the lowest set request index wins.
module irq_prio_enc #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] req,
    output logic [2:0]       idx,
    output logic             valid
);

    always_comb begin
        idx   = '0;
        valid = |req;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = 3'(i);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Edge-detecting interrupt controller with CPU-visible flag/enable registers
// and a three-state request/acknowledge handshake toward the CPU.
module irq_controller
    import irq_pkg::*;
#(
    parameter int          NUM_IRQ    = 5,
    parameter logic [15:0] IF_ADDR    = IRQ_IF_ADDR,
    parameter logic [15:0] IE_ADDR    = IRQ_IE_ADDR,
    parameter logic [15:0] VEC_BASE   = IRQ_VEC_BASE,
    parameter int          VEC_STRIDE = IRQ_VEC_STRIDE
) (
    input  logic               I_CLOCK,
    input  logic               I_RESET,
    input  logic [NUM_IRQ-1:0] I_IRQ,
    input  logic               I_MEM_WE_L,
    input  logic [15:0]        I_CPU_ADDR,
    input  logic [7:0]         I_CPU_DATA,
    input  logic               I_IME,
    input  logic               I_INT_ACK,
    output logic [7:0]         O_IF,
    output logic [7:0]         O_IE,
    output logic               O_INT_REQ,
    output logic [15:0]        O_INT_VECTOR,
    output logic [2:0]         O_INT_ID,
    output logic               O_WAKE,
    output logic [NUM_IRQ-1:0] O_ACK
);

    logic [NUM_IRQ-1:0] irq_prev_reg;
    logic [NUM_IRQ-1:0] irq_armed_reg;
    logic [NUM_IRQ-1:0] if_reg, if_next;
    logic [7:0]         ie_reg, ie_next;
    irq_state_e         state_reg, state_next;
    logic [2:0]         id_reg, id_next;
    logic [15:0]        vector_reg, vector_next;
    logic [NUM_IRQ-1:0] ack_reg, ack_next;

    logic [NUM_IRQ-1:0] irq_edge;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] ack_mask;
    logic [NUM_IRQ-1:0] ack_clr;
    logic [NUM_IRQ-1:0] if_no_ack;
    logic               wr_if, wr_ie;
    logic               accept;
    logic [2:0]         enc_idx;
    logic               enc_valid;

    assign wr_if = !I_MEM_WE_L && (I_CPU_ADDR == IF_ADDR);
    assign wr_ie = !I_MEM_WE_L && (I_CPU_ADDR == IE_ADDR);

    // A channel is armed once it has been seen low; a line held high through
    // reset therefore needs a fresh low-to-high transition to raise its flag.
    assign irq_edge = I_IRQ & ~irq_prev_reg & irq_armed_reg;
    assign pending  = if_reg & ie_reg[NUM_IRQ-1:0];
    assign accept   = (state_reg == ST_REQUEST) && I_INT_ACK;
    assign ack_clr  = accept ? ack_mask : '0;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_IRQ; gi++) begin : g_ack_mask
            assign ack_mask[gi] = (id_reg == 3'(gi));
        end
        for (gi = 0; gi < IRQ_MAX_CH; gi++) begin : g_if_read
            if (gi < NUM_IRQ) begin : g_used
                assign O_IF[gi] = if_reg[gi];
            end else begin : g_unused
                assign O_IF[gi] = 1'b1;
            end
        end
    endgenerate

    // Flag update order: edge set beats a CPU write, which beats the ack clear.
    always_comb begin
        if_no_ack = (wr_if ? I_CPU_DATA[NUM_IRQ-1:0] : if_reg) | irq_edge;
        if_next   = (wr_if ? I_CPU_DATA[NUM_IRQ-1:0] : (if_reg & ~ack_clr)) | irq_edge;
        ie_next   = wr_ie ? I_CPU_DATA : ie_reg;
    end

    irq_prio_enc #(
        .WIDTH(NUM_IRQ)
    ) u_prio_enc (
        .req  (pending),
        .idx  (enc_idx),
        .valid(enc_valid)
    );

    always_comb begin
        state_next  = state_reg;
        id_next     = id_reg;
        vector_next = vector_reg;
        ack_next    = '0;
        unique case (state_reg)
            ST_IDLE: begin
                if (I_IME && enc_valid) begin
                    state_next  = ST_REQUEST;
                    id_next     = enc_idx;
                    vector_next = irq_vector(VEC_BASE, VEC_STRIDE, enc_idx);
                end
            end
            ST_REQUEST: begin
                if (accept) begin
                    ack_next   = ack_mask;
                    state_next = ST_DISPATCH;
                end else if (!I_IME || ((if_no_ack & ack_mask) == '0)) begin
                    // Withdrawn: the latched flag stays as software left it.
                    state_next = ST_IDLE;
                end
            end
            ST_DISPATCH: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge I_CLOCK) begin
        if (I_RESET) begin
            irq_prev_reg  <= '0;
            irq_armed_reg <= ~I_IRQ;
            if_reg        <= '0;
            ie_reg        <= '0;
            state_reg     <= ST_IDLE;
            id_reg        <= '0;
            vector_reg    <= VEC_BASE;
            ack_reg       <= '0;
        end else begin
            irq_prev_reg  <= I_IRQ;
            irq_armed_reg <= irq_armed_reg | ~I_IRQ;
            if_reg        <= if_next;
            ie_reg        <= ie_next;
            state_reg     <= state_next;
            id_reg        <= id_next;
            vector_reg    <= vector_next;
            ack_reg       <= ack_next;
        end
    end

    assign O_IE         = ie_reg;
    assign O_INT_REQ    = (state_reg == ST_REQUEST);
    assign O_INT_VECTOR = vector_reg;
    assign O_INT_ID     = id_reg;
    assign O_WAKE       = |pending;
    assign O_ACK        = ack_reg;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a model.
module tb_irq_controller;

    localparam int N = 5;

    logic         clk = 1'b0;
    logic         srst;
    logic [N-1:0] irq;
    logic         we_l;
    logic [15:0]  addr;
    logic [7:0]   data;
    logic         ime;
    logic         int_ack;
    logic [7:0]   o_if;
    logic [7:0]   o_ie;
    logic         o_int_req;
    logic [15:0]  o_int_vector;
    logic [2:0]   o_int_id;
    logic         o_wake;
    logic [N-1:0] o_ack;

    always #5 clk = ~clk;

    irq_controller #(
        .NUM_IRQ(N)
    ) dut (
        .I_CLOCK     (clk),
        .I_RESET     (srst),
        .I_IRQ       (irq),
        .I_MEM_WE_L  (we_l),
        .I_CPU_ADDR  (addr),
        .I_CPU_DATA  (data),
        .I_IME       (ime),
        .I_INT_ACK   (int_ack),
        .O_IF        (o_if),
        .O_IE        (o_ie),
        .O_INT_REQ   (o_int_req),
        .O_INT_VECTOR(o_int_vector),
        .O_INT_ID    (o_int_id),
        .O_WAKE      (o_wake),
        .O_ACK       (o_ack)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: flags, enables, and the "request outstanding" /
    // "just dispatched" status derived directly from the handshake rules.
    bit [N-1:0]  m_if, m_last, m_ack, m_pend, m_edges, m_nif;
    bit [7:0]    m_ie;
    bit          m_req, m_disp, m_acked;
    bit [2:0]    m_id;
    bit [15:0]   m_vec;

    always @(posedge clk) begin
        if (srst) begin
            m_if   = '0;
            m_ie   = '0;
            m_req  = 1'b0;
            m_disp = 1'b0;
            m_ack  = '0;
            m_id   = '0;
            m_vec  = 16'h0040;
            m_last = irq;
        end else begin
            m_edges = irq & ~m_last;
            m_last  = irq;
            m_acked = m_req && int_ack;
            m_nif   = m_if;
            if (m_acked) m_nif[m_id] = 1'b0;
            if (!we_l && addr == 16'hFF0F) m_nif = data[N-1:0];
            m_nif  = m_nif | m_edges;
            m_pend = m_if & m_ie[N-1:0];
            if (!we_l && addr == 16'hFFFF) m_ie = data;
            m_ack = '0;
            if (m_disp) begin
                m_disp = 1'b0;
            end else if (m_req) begin
                if (m_acked) begin
                    m_req        = 1'b0;
                    m_disp       = 1'b1;
                    m_ack[m_id]  = 1'b1;
                end else if (!ime || !m_nif[m_id]) begin
                    m_req = 1'b0;
                end
            end else if (ime && m_pend != '0) begin
                m_req = 1'b1;
                for (int i = N - 1; i >= 0; i--) begin
                    if (m_pend[i]) m_id = 3'(i);
                end
                m_vec = 16'h0040 + 16'(m_id) * 16'd8;
            end
            m_if = m_nif;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_if",     o_if,         {3'b111, m_if});
            chk("model_ie",     o_ie,         m_ie);
            chk("model_req",    o_int_req,    m_req);
            chk("model_vector", o_int_vector, m_vec);
            chk("model_id",     o_int_id,     m_id);
            chk("model_wake",   o_wake,       |(m_if & m_ie[N-1:0]));
            chk("model_ack",    o_ack,        m_ack);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        we_l = 1'b0;
        addr = a;
        data = d;
        tick();
        we_l = 1'b1;
        addr = 16'h0000;
    endtask

    initial begin
        srst = 1'b1; irq = '0; we_l = 1'b1; addr = '0; data = '0; ime = 1'b0; int_ack = 1'b0;
        tick(); tick();
        chk("rst_if", o_if, 8'hE0);
        chk("rst_ie", o_ie, 8'h00);
        chk("rst_req", o_int_req, 1'b0);
        chk("rst_vec", o_int_vector, 16'h0040);
        chk("rst_id", o_int_id, 3'd0);
        chk("rst_ack", o_ack, 5'b00000);
        chk_en = 1'b1;
        srst = 1'b0;
        $display("txn reset: outputs checked");

        // Single channel request and acknowledge
        wr(16'hFFFF, 8'h1F);
        ime = 1'b1; irq[0] = 1'b1; tick();
        chk("s1_if_set", o_if, 8'hE1);
        chk("s1_req_early", o_int_req, 1'b0);
        irq[0] = 1'b0; tick();
        chk("s1_req", o_int_req, 1'b1);
        chk("s1_vec", o_int_vector, 16'h0040);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        chk("s1_ack", o_ack, 5'b00001);
        chk("s1_if_clr", o_if, 8'hE0);
        tick(); tick();
        $display("txn single irq0 request/ack");

        // Two simultaneous sources: lowest index first
        wr(16'hFFFF, 8'h14);
        irq = 5'b10100; tick(); tick();
        chk("s2_req", o_int_req, 1'b1);
        chk("s2_id_a", o_int_id, 3'd2);
        chk("s2_vec_a", o_int_vector, 16'h0050);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        chk("s2_ack_a", o_ack, 5'b00100);
        tick();
        chk("s2_idle_gap", o_int_req, 1'b0);
        tick();
        chk("s2_id_b", o_int_id, 3'd4);
        chk("s2_vec_b", o_int_vector, 16'h0060);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        chk("s2_ack_b", o_ack, 5'b10000);
        irq = '0; tick(); tick();
        $display("txn priority irq2 then irq4");

        // Wake independent of IME
        ime = 1'b0; wr(16'hFFFF, 8'h00);
        irq[3] = 1'b1; tick(); tick();
        chk("s3_wake_off", o_wake, 1'b0);
        wr(16'hFFFF, 8'h08);
        chk("s3_wake_on", o_wake, 1'b1);
        chk("s3_no_req", o_int_req, 1'b0);
        tick();
        chk("s3_no_req2", o_int_req, 1'b0);
        ime = 1'b1; tick();
        chk("s3_req", o_int_req, 1'b1);
        chk("s3_vec", o_int_vector, 16'h0058);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        irq = '0; tick(); tick();
        $display("txn wake and irq3 dispatch");

        // CPU write collides with an edge
        ime = 1'b0; irq[1] = 1'b1;
        wr(16'hFF0F, 8'h55);
        chk("s4_if_merge", o_if, 8'hF7);
        $display("txn if write with same-cycle edge");

        // Withdraw on IME drop
        wr(16'hFFFF, 8'h01);
        ime = 1'b1; tick();
        chk("s5_req", o_int_req, 1'b1);
        chk("s5_id", o_int_id, 3'd0);
        ime = 1'b0; tick();
        chk("s5_withdraw", o_int_req, 1'b0);
        chk("s5_if_kept", o_if, 8'hF7);
        chk("s5_no_ack", o_ack, 5'b00000);
        $display("txn withdraw on ime drop");

        // Reset during request with a source held high
        irq = 5'b00001; ime = 1'b1; tick();
        chk("s6_req", o_int_req, 1'b1);
        srst = 1'b1; tick();
        chk("s6_rst_req", o_int_req, 1'b0);
        chk("s6_rst_ack", o_ack, 5'b00000);
        chk("s6_rst_if", o_if, 8'hE0);
        chk("s6_rst_ie", o_ie, 8'h00);
        chk("s6_rst_vec", o_int_vector, 16'h0040);
        chk("s6_rst_id", o_int_id, 3'd0);
        tick(); srst = 1'b0;
        wr(16'hFFFF, 8'h1F);
        tick(); tick();
        chk("s6_held_no_set", o_if, 8'hE0);
        irq[0] = 1'b0; tick();
        chk("s6_fall_no_set", o_if, 8'hE0);
        irq[0] = 1'b1; tick();
        chk("s6_rearm_set", o_if, 8'hE1);
        $display("txn reset during request, held source");

        // Randomized traffic checked by the model every cycle
        for (int c = 0; c < 600; c++) begin
            srst = ($urandom_range(0, 63) == 0);
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 3) == 0) irq[b] = ~irq[b];
            end
            we_l = ($urandom_range(0, 7) != 0);
            case ($urandom_range(0, 2))
                0: addr = 16'hFF0F;
                1: addr = 16'hFFFF;
                default: addr = 16'($urandom);
            endcase
            data    = 8'($urandom);
            ime     = ($urandom_range(0, 3) != 0);
            int_ack = 1'($urandom_range(0, 1));
            tick();
        end
        $display("txn random: 600 cycles");

        srst = 1'b0; we_l = 1'b1; int_ack = 1'b0;
        tick();
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
